// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with two-flop row synchronizer, debounce and one-cycle key strobe.
// Optional auto-repeat while a key stays down is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int unsigned SCAN_CYCLES     = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned REPEAT_CYCLES   = 13500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic       key_pressed,
   output logic [3:0] key_value,
   output logic       key_held
);

   localparam int unsigned ScanW = $clog2(SCAN_CYCLES);
   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e           r_state, w_state_d;
   logic [3:0]       r_sync, r_rs;
   logic [1:0]       r_col, w_col_d;
   logic [ScanW-1:0] r_scan_cnt, w_scan_cnt_d;
   logic [DbW-1:0]   r_db_cnt, w_db_cnt_d;
   logic [3:0]       r_lcode, w_lcode_d;
   logic             r_pressed, w_pressed_d;
   logic [3:0]       r_value, w_value_d;
   logic             w_rep_fire;

   // Lowest low row wins when several rows are down in the active column.
   function automatic logic [3:0] encode(input logic [3:0] rows, input logic [1:0] col);
      logic [1:0] r;
      logic [3:0] v;
      if (!rows[0])      r = 2'd0;
      else if (!rows[1]) r = 2'd1;
      else if (!rows[2]) r = 2'd2;
      else               r = 2'd3;
      case ({r, col})
         4'b00_00: v = 4'h1;
         4'b00_01: v = 4'h2;
         4'b00_10: v = 4'h3;
         4'b00_11: v = 4'hA;
         4'b01_00: v = 4'h4;
         4'b01_01: v = 4'h5;
         4'b01_10: v = 4'h6;
         4'b01_11: v = 4'hB;
         4'b10_00: v = 4'h7;
         4'b10_01: v = 4'h8;
         4'b10_10: v = 4'h9;
         4'b10_11: v = 4'hC;
         4'b11_00: v = 4'hE;
         4'b11_01: v = 4'h0;
         4'b11_10: v = 4'hF;
         default:  v = 4'hD;
      endcase
      return v;
   endfunction

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RepW = $clog2(REPEAT_CYCLES);
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

   logic [RepW-1:0] r_rep_cnt, w_rep_cnt_d;

   // Held at zero outside HELD, so entry to HELD always starts a fresh period.
   always_comb begin
      w_rep_cnt_d = r_rep_cnt;
      w_rep_fire  = 1'b0;
      if (r_state != StHeld || r_rs != r_lcode) begin
         w_rep_cnt_d = '0;
      end else if (r_rep_cnt == RepLast) begin
         w_rep_cnt_d = '0;
         w_rep_fire  = 1'b1;
      end else begin
         w_rep_cnt_d = r_rep_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rep_cnt <= '0;
      else      r_rep_cnt <= w_rep_cnt_d;
   end
`else
   logic w_unused_repeat;
   assign w_unused_repeat = (REPEAT_CYCLES > 0);
   assign w_rep_fire      = 1'b0;
`endif

   always_comb begin
      w_state_d    = r_state;
      w_col_d      = r_col;
      w_scan_cnt_d = r_scan_cnt;
      w_db_cnt_d   = r_db_cnt;
      w_lcode_d    = r_lcode;
      w_pressed_d  = w_rep_fire;
      w_value_d    = r_value;
      unique case (r_state)
         StScan: begin
            if (r_scan_cnt == ScanLast) begin
               if (r_rs == 4'hF) begin
                  w_col_d      = r_col + 2'd1;
                  w_scan_cnt_d = '0;
               end else begin
                  w_lcode_d  = r_rs;
                  w_state_d  = StDebounce;
                  w_db_cnt_d = '0;
               end
            end else begin
               w_scan_cnt_d = r_scan_cnt + 1'b1;
            end
         end
         StDebounce: begin
            if (r_rs == 4'hF) begin
               w_state_d    = StScan;
               w_col_d      = r_col + 2'd1;
               w_scan_cnt_d = '0;
            end else if (r_rs != r_lcode) begin
               w_lcode_d  = r_rs;
               w_db_cnt_d = '0;
            end else if (r_db_cnt == DbLast) begin
               w_state_d   = StHeld;
               w_pressed_d = 1'b1;
               w_value_d   = encode(r_lcode, r_col);
               w_db_cnt_d  = '0;
            end else begin
               w_db_cnt_d = r_db_cnt + 1'b1;
            end
         end
         StHeld: begin
            // Debounce counter doubles as the release counter here.
            if (r_rs != 4'hF) begin
               w_db_cnt_d = '0;
            end else if (r_db_cnt == DbLast) begin
               w_state_d    = StScan;
               w_col_d      = r_col + 2'd1;
               w_scan_cnt_d = '0;
            end else begin
               w_db_cnt_d = r_db_cnt + 1'b1;
            end
         end
         default: w_state_d = StScan;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StScan;
         r_sync     <= 4'hF;
         r_rs       <= 4'hF;
         r_col      <= 2'd0;
         r_scan_cnt <= '0;
         r_db_cnt   <= '0;
         r_lcode    <= 4'hF;
         r_pressed  <= 1'b0;
         r_value    <= 4'h0;
      end else begin
         r_state    <= w_state_d;
         r_sync     <= row_i;
         r_rs       <= r_sync;
         r_col      <= w_col_d;
         r_scan_cnt <= w_scan_cnt_d;
         r_db_cnt   <= w_db_cnt_d;
         r_lcode    <= w_lcode_d;
         r_pressed  <= w_pressed_d;
         r_value    <= w_value_d;
      end
   end

   assign col_o       = ~(4'b0001 << r_col);
   assign key_pressed = r_pressed;
   assign key_value   = r_value;
   assign key_held    = (r_state == StHeld);

endmodule
